instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes one MIPS instruction per handshake from a mnemonic selector plus operand fields into a 32-bit instruction word, tags it with an instruction-memory word address, and buffers it in a small FIFO for the instruction-memory loader. It produces the same opcode/funct encodings that the control unit decodes. It sits between the test/program-load path and instruction memory.

## Interface
- ADDR_W, 8: width of the instruction-memory word address.
- DEPTH, 4: FIFO entries. Must be a power of two and ≥2.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle; equals (level != DEPTH).
- op_sel  in  5  mnemonic code (see Operation).
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate; passed through unmodified.
- target  in  26  jump target.
- addr_load  in  1  1-cycle pulse; loads addr_in into the address counter.
- addr_in  in  ADDR_W  address to load.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_addr  out  ADDR_W  head address.
- out_word  out  32  head instruction word.
- err  out  1  1-cycle pulse: illegal op_sel accepted.
- err_count  out  8  saturating count of illegal op_sel values.
- level  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept: in_valid && in_ready on a clock edge.
- op_sel map:
  - 0 ADD: R-type, funct 100000.
  - 1 SUB: R-type, funct 100010.
  - 2 AND: R-type, funct 100100.
  - 3 OR: R-type, funct 100101.
  - 4 SLT: R-type, funct 101010.
  - 5 LW: opcode 100011.
  - 6 SW: opcode 101011.
  - 7 BEQ: opcode 000100.
  - 8 BNE: opcode 000101.
  - 9 ADDI: opcode 001000.
  - 10 SUBI: opcode 001010.
  - 11 LUI: opcode 001111.
  - 12 ORI: opcode 001101.
  - 13 J: opcode 000010.
  - 14 JAL: opcode 000011.
  - 15 NOT: opcode 011100.
  - 16 MULT: opcode 011000.
  - 17 DIV: opcode 011010.
  - 18–31: illegal.
- Formats:
  - R-type: {000000, rs, rt, rd, 00000, funct}.
  - I-type (5–12): {opcode, rs, rt, imm}. LUI forces the rs field to 0.
  - J-type (13, 14): {opcode, target}.
  - NOT: {011100, rs, 00000, rd, 00000, 000000}.
  - MULT/DIV: {opcode, rs, rt, 16'b0}.
- Legal accept:
  - Push {addr_cnt_eff, word} into the FIFO.
  - addr_cnt ← addr_cnt_eff + 1, modulo 2^ADDR_W (wraps 2^ADDR_W−1 → 0).
  - addr_cnt_eff = addr_in if addr_load is high that cycle, else addr_cnt.
- Illegal accept:
  - No push; address counter unchanged.
  - err asserted the next cycle for exactly one cycle.
  - err_count increments and saturates at 255.
- addr_load without an accept: addr_cnt ← addr_in.
- FIFO:
  - Circular, first in first out.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - When full, in_ready=0. A simultaneous pop does not open a push slot that cycle.
  - Empty: out_valid=0; out_addr/out_word don't-care but stable.

## Timing
- Reset values: level=0, out_valid=0, in_ready=1, err=0, err_count=0, addr_cnt=0, out_word=0, out_addr=0.
- Reset is asynchronous and takes effect mid-operation; buffered entries are discarded.
- Latency: a word accepted at edge N is at the head with out_valid=1 after edge N when the FIFO was empty (visible in cycle N+1).
- out_valid and level are registered.
- in_ready is combinational from level only; it does not depend on in_valid or out_ready.
- Head stability: out_word and out_addr hold until popped.
- Throughput: one accept and one pop per cycle sustained.

## Test plan
- ADD rs=1 rt=2 rd=3 after reset -> out_word=0x00221820, out_addr=0x00, out_valid rises one cycle after accept.
- Sequential I-type and J-type encodes:
  - LW rs=29 rt=8 imm=0x0004 -> 0x8FA80004 @ addr 0.
  - ADDI rs=0 rt=1 imm=0xFFFF -> 0x2001FFFF @ addr 1.
  - J target=0x0000010 -> 0x08000010 @ addr 2.
  - JAL target=0x3FFFFFF -> 0x0FFFFFFF @ addr 3.
- Backpressure:
  - With out_ready=0, offer 5 back-to-back ADDI -> 4 accepted, in_ready=0 after the 4th, level=4.
  - Then out_ready=1 -> drains addrs 0,1,2,3 in order, one per cycle; the 5th is accepted on the first cycle with level<4.
- Illegal op_sel=20 then ADD -> err high one cycle, err_count=1, no FIFO entry; ADD gets addr 0.
- Address wrap and collision:
  - With ADDR_W=8, addr_load addr_in=0xFF together with an accepted ORI, then one ADD -> addrs 0xFF then 0x00.
- Reset mid-operation with level=3 and err_count=2 -> level=0, out_valid=0, err_count=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake bundle between the program-load path and the instruction encoder.
// master drives operands and out_ready; slave is the encoder itself.
interface instr_encoder_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_word;
    logic              err;
    logic [7:0]        err_count;
    logic [LVL_W-1:0]  level;

    modport master (
        output in_valid, op_sel, rs, rt, rd, imm, target, addr_load, addr_in, out_ready,
        input  in_ready, out_valid, out_addr, out_word, err, err_count, level
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, imm, target, addr_load, addr_in, out_ready,
        output in_ready, out_valid, out_addr, out_word, err, err_count, level
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns a mnemonic plus operand fields into a 32-bit word,
// tags it with an instruction-memory address and queues it for the memory loader.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_SLT  = 5'd4,  OP_LW   = 5'd5,  OP_SW   = 5'd6,  OP_BEQ  = 5'd7,
        OP_BNE  = 5'd8,  OP_ADDI = 5'd9,  OP_SUBI = 5'd10, OP_LUI  = 5'd11,
        OP_ORI  = 5'd12, OP_J    = 5'd13, OP_JAL  = 5'd14, OP_NOT  = 5'd15,
        OP_MULT = 5'd16, OP_DIV  = 5'd17
    } op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } entry_t;

    function automatic logic [31:0] r_type(input logic [5:0] funct,
                                           input logic [4:0] rs_f, rt_f, rd_f);
        return {6'b000000, rs_f, rt_f, rd_f, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opcode,
                                           input logic [4:0] rs_f, rt_f,
                                           input logic [15:0] imm_f);
        return {opcode, rs_f, rt_f, imm_f};
    endfunction

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic              out_valid_q;
    logic              err_q;
    logic [7:0]        err_count_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_eff;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (bus.op_sel)
            OP_ADD:  word = r_type(6'b100000, bus.rs, bus.rt, bus.rd);
            OP_SUB:  word = r_type(6'b100010, bus.rs, bus.rt, bus.rd);
            OP_AND:  word = r_type(6'b100100, bus.rs, bus.rt, bus.rd);
            OP_OR:   word = r_type(6'b100101, bus.rs, bus.rt, bus.rd);
            OP_SLT:  word = r_type(6'b101010, bus.rs, bus.rt, bus.rd);
            OP_LW:   word = i_type(6'b100011, bus.rs, bus.rt, bus.imm);
            OP_SW:   word = i_type(6'b101011, bus.rs, bus.rt, bus.imm);
            OP_BEQ:  word = i_type(6'b000100, bus.rs, bus.rt, bus.imm);
            OP_BNE:  word = i_type(6'b000101, bus.rs, bus.rt, bus.imm);
            OP_ADDI: word = i_type(6'b001000, bus.rs, bus.rt, bus.imm);
            OP_SUBI: word = i_type(6'b001010, bus.rs, bus.rt, bus.imm);
            OP_LUI:  word = i_type(6'b001111, 5'd0,   bus.rt, bus.imm);
            OP_ORI:  word = i_type(6'b001101, bus.rs, bus.rt, bus.imm);
            OP_J:    word = {6'b000010, bus.target};
            OP_JAL:  word = {6'b000011, bus.target};
            OP_NOT:  word = {6'b011100, bus.rs, 5'd0, bus.rd, 11'd0};
            OP_MULT: word = {6'b011000, bus.rs, bus.rt, 16'd0};
            OP_DIV:  word = {6'b011010, bus.rs, bus.rt, 16'd0};
            default: legal = 1'b0;
        endcase
    end

    // in_ready looks only at the registered level, so a same-cycle pop never frees a slot.
    assign bus.in_ready  = (level_q != FULL);
    assign accept        = bus.in_valid & bus.in_ready;
    assign push          = accept & legal;
    assign pop           = out_valid_q & bus.out_ready;
    assign addr_eff      = bus.addr_load ? bus.addr_in : addr_cnt;
    assign level_nxt     = level_q + LVL_W'(push) - LVL_W'(pop);

    assign bus.out_valid = out_valid_q;
    assign bus.level     = level_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.out_addr  = mem[rd_ptr].addr;
    assign bus.out_word  = mem[rd_ptr].word;

    // NOTE: the storage array is cleared on reset so the head reads zero out of reset and is never X when empty.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            addr_cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {addr_eff, word};
                wr_ptr      <= wr_ptr + 1'b1;
                addr_cnt    <= addr_eff + 1'b1;
            end else if (bus.addr_load && !accept) begin
                addr_cnt <= bus.addr_in;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level_q     <= level_nxt;
            out_valid_q <= (level_nxt != '0);
            err_q       <= accept & ~legal;
            if (accept && !legal && err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a cycle-level reference model queues expected
// {addr, word} entries and a negedge monitor compares whatever the DUT presents.
module tb_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the mnemonic table; returns {legal, word}.
    function automatic logic [32:0] ref_encode(input longint op, input longint rs_v, rt_v, rd_v,
                                               input longint imm_v, tgt_v);
        longint r_funct [5] = '{32, 34, 36, 37, 42};
        longint i_opc   [8] = '{35, 43, 4, 5, 8, 10, 15, 13};
        longint w;
        if (op <= 4)
            w = rs_v * (1 << 21) + rt_v * (1 << 16) + rd_v * (1 << 11) + r_funct[op];
        else if (op <= 12)
            w = i_opc[op - 5] * (1 << 26) + ((op == 11) ? 0 : rs_v) * (1 << 21)
                + rt_v * (1 << 16) + imm_v;
        else if (op == 13 || op == 14)
            w = (op - 11) * (1 << 26) + tgt_v;
        else if (op == 15)
            w = 28 * (1 << 26) + rs_v * (1 << 21) + rd_v * (1 << 11);
        else if (op == 16 || op == 17)
            w = (op == 16 ? 24 : 26) * (1 << 26) + rs_v * (1 << 21) + rt_v * (1 << 16);
        else
            return 33'd0;
        return {1'b1, w[31:0]};
    endfunction

    logic [39:0] exp_q[$];
    int          level_m = 0;
    int          errc_m  = 0;
    logic        err_m   = 1'b0;
    logic [7:0]  addr_m  = 8'd0;
    logic [7:0]  eff_m;
    logic [32:0] enc_m;
    logic        acc_m;
    logic        pop_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            level_m = 0;
            errc_m  = 0;
            err_m   = 1'b0;
            addr_m  = 8'd0;
            exp_q.delete();
        end else begin
            acc_m = bus.in_valid && (level_m != DEPTH);
            pop_m = (level_m != 0) && bus.out_ready;
            enc_m = ref_encode(longint'(bus.op_sel), longint'(bus.rs), longint'(bus.rt),
                               longint'(bus.rd), longint'(bus.imm), longint'(bus.target));
            eff_m = bus.addr_load ? bus.addr_in : addr_m;
            err_m = acc_m && !enc_m[32];
            if (err_m && errc_m != 255) errc_m++;
            if (acc_m && enc_m[32]) begin
                exp_q.push_back({eff_m, enc_m[31:0]});
                addr_m = eff_m + 8'd1;
                level_m++;
            end else if (bus.addr_load && !acc_m) begin
                addr_m = bus.addr_in;
            end
            if (pop_m) level_m--;
        end
    end

    logic [39:0] head_m;
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready",  64'(bus.in_ready),  64'(level_m != DEPTH));
            check("level",     64'(bus.level),     64'(level_m));
            check("out_valid", 64'(bus.out_valid), 64'(level_m != 0));
            check("err",       64'(bus.err),       64'(err_m));
            check("err_count", 64'(bus.err_count), 64'(errc_m));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_head", 64'(bus.out_valid), 64'd0);
                end else begin
                    head_m = bus.out_ready ? exp_q.pop_front() : exp_q[0];
                    check("head_addr", 64'(bus.out_addr), 64'(head_m[39:32]));
                    check("head_word", 64'(bus.out_word), 64'(head_m[31:0]));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.op_sel    = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd        = '0;
        bus.imm       = '0;
        bus.target    = '0;
        bus.addr_load = 1'b0;
        bus.addr_in   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Holds a bundle until accepted; returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rs_v, rt_v, rd_v,
                        input logic [15:0] imm_v, input logic [25:0] tgt_v,
                        input logic load, input logic [7:0] ain);
        logic acc;
        int   guard;
        bus.in_valid  = 1'b1;
        bus.op_sel    = op;
        bus.rs        = rs_v;
        bus.rt        = rt_v;
        bus.rd        = rd_v;
        bus.imm       = imm_v;
        bus.target    = tgt_v;
        bus.addr_load = load;
        bus.addr_in   = ain;
        guard = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        idle_inputs();
    endtask

    task automatic expect_head(input string nm, input logic [7:0] a, input logic [31:0] w);
        check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({nm, "_addr"},  64'(bus.out_addr),  64'(a));
        check({nm, "_word"},  64'(bus.out_word),  64'(w));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b0;
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        check("rst_level",     64'(bus.level),     64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_err",       64'(bus.err),       64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        check("rst_out_word",  64'(bus.out_word),  64'd0);
        check("rst_out_addr",  64'(bus.out_addr),  64'd0);

        // ADD right after reset: visible one edge after acceptance
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 8'd0);
        expect_head("add", 8'h00, 32'h00221820);

        // I-type and J-type sequence
        do_reset();
        send(5'd5,  5'd29, 5'd8, 5'd0, 16'h0004, 26'd0,        1'b0, 8'd0);
        send(5'd9,  5'd0,  5'd1, 5'd0, 16'hFFFF, 26'd0,        1'b0, 8'd0);
        send(5'd13, 5'd0,  5'd0, 5'd0, 16'd0,    26'h0000010,  1'b0, 8'd0);
        send(5'd14, 5'd0,  5'd0, 5'd0, 16'd0,    26'h3FFFFFF,  1'b0, 8'd0);
        expect_head("lw",   8'h00, 32'h8FA80004);
        expect_head("addi", 8'h01, 32'h2001FFFF);
        expect_head("j",    8'h02, 32'h08000010);
        expect_head("jal",  8'h03, 32'h0FFFFFFF);

        // Backpressure: fill, stall a 5th, then drain
        do_reset();
        for (int i = 0; i < 4; i++)
            send(5'd9, 5'(i), 5'(i + 1), 5'd0, 16'(i), 26'd0, 1'b0, 8'd0);
        bus.in_valid = 1'b1;
        bus.op_sel   = 5'd9;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_level",    64'(bus.level),    64'd4);
        bus.out_ready = 1'b1;
        send(5'd9, 5'd4, 5'd5, 5'd0, 16'd4, 26'd0, 1'b0, 8'd0);
        bus.out_ready = 1'b0;
        expect_head("bp2", 8'h02, 32'h20430002);
        expect_head("bp3", 8'h03, 32'h20640003);
        expect_head("bp4", 8'h04, 32'h20850004);

        // Illegal op_sel then ADD
        do_reset();
        send(5'd20, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 8'd0);
        check("ill_err",       64'(bus.err),       64'd1);
        check("ill_err_count", 64'(bus.err_count), 64'd1);
        check("ill_level",     64'(bus.level),     64'd0);
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 8'd0);
        check("ill_err_clear", 64'(bus.err), 64'd0);
        expect_head("after_ill", 8'h00, 32'h00221820);

        // Address load colliding with an accept, then wrap
        do_reset();
        send(5'd12, 5'd3, 5'd4, 5'd0, 16'h1234, 26'd0, 1'b1, 8'hFF);
        send(5'd0,  5'd1, 5'd2, 5'd3, 16'd0,    26'd0, 1'b0, 8'd0);
        expect_head("wrap_ori", 8'hFF, 32'h34641234);
        expect_head("wrap_add", 8'h00, 32'h00221820);

        // Asynchronous reset mid-operation
        do_reset();
        send(5'd20, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 8'd0);
        send(5'd25, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++)
            send(5'd0, 5'(i), 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 8'd0);
        check("pre_rst_level",     64'(bus.level),     64'd3);
        check("pre_rst_err_count", 64'(bus.err_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_level",     64'(bus.level),     64'd0);
        check("async_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_err_count", 64'(bus.err_count), 64'd0);
        check("async_in_ready",  64'(bus.in_ready),  64'd1);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op_sel    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31))
                                                        : 5'($urandom_range(0, 17));
            bus.rs        = 5'($urandom);
            bus.rt        = 5'($urandom);
            bus.rd        = 5'($urandom);
            bus.imm       = 16'($urandom);
            bus.target    = 26'($urandom);
            bus.addr_load = ($urandom_range(0, 15) == 0);
            bus.addr_in   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end

        // Saturate the illegal counter
        bus.out_ready = 1'b1;
        bus.addr_load = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op_sel    = 5'd31;
        repeat (260) begin
            @(posedge clk);
            #1;
        end
        check("err_count_sat", 64'(bus.err_count), 64'd255);

        idle_inputs();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
